// File: rtl/zeroriscy_defines.sv
// Shared definitions for the zeroriscy instruction fetch path.
//   PREFETCH_DEPTH : number of 32-bit words the prefetch FIFO can hold
//   is_compressed  : true when a parcel's low two bits mark an RVC instruction
package zeroriscy_defines;

  localparam int PREFETCH_DEPTH = 3;

  function automatic logic is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/zeroriscy_fetch_fifo.sv
// Prefetch word buffer with RVC realignment.
// Holds fetched 32-bit words (entry0 is the oldest), tracks the PC of the
// presented instruction and forms the 32-bit parcel starting at that PC,
// which may straddle entry0 and entry1 when the PC is halfword aligned.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : flush all entries and load clear_addr as the new PC
//   clear_addr   : redirect target (halfword aligned)
//   push         : write push_data behind the current entries
//   push_data    : fetched word
//   ready        : consumer takes the presented instruction
//   valid        : rdata/addr hold a complete instruction
//   rdata        : parcel starting at addr
//   addr         : PC of the presented instruction
//   room         : occupancy after this cycle's pop and push is below DEPTH-1,
//                  so one more fetch may be launched without risking overflow
module zeroriscy_fetch_fifo
  import zeroriscy_defines::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [31:0] clear_addr,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] rdata,
  output logic [31:0] addr,
  output logic        room
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] ROOM_LIM = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_pop, count_d;
  logic [31:0]      addr_q, addr_d;
  logic             e0_vld, e1_vld, unaligned, compressed, consume, pop;

  assign e0_vld    = count_q != '0;
  assign e1_vld    = count_q >= TWO;
  assign unaligned = addr_q[1];

  // An unaligned parcel whose first half marks a 32-bit instruction needs
  // the low half of the following word before it can be presented.
  always_comb begin
    if (unaligned) begin
      rdata = {data_q[1][15:0], data_q[0][31:16]};
      valid = e0_vld & (is_compressed(data_q[0][17:16]) | e1_vld);
    end else begin
      rdata = data_q[0];
      valid = e0_vld;
    end
  end

  assign compressed = is_compressed(rdata[1:0]);
  assign consume    = valid & ready & ~clear;
  // An aligned compressed instruction leaves its upper half still to be used.
  assign pop        = consume & (unaligned | ~compressed);
  assign count_pop  = count_q - CNT_W'(pop);
  assign room       = (count_pop + CNT_W'(push)) < ROOM_LIM;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) data_d[i] = data_q[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i + 1];
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_pop == CNT_W'(i)) data_d[i] = push_data;
      end
    end
  end

  assign count_d = clear ? '0 : count_pop + CNT_W'(push);

  always_comb begin
    addr_d = addr_q;
    if (clear) begin
      addr_d = clear_addr;
    end else if (consume) begin
      addr_d = addr_q + (compressed ? 32'd2 : 32'd4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  assign addr = addr_q;

  // The fetch side only launches a request while there is room, so a push
  // into a full buffer means the issue rule was broken.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_pop == FULL)));

endmodule

// File: rtl/zeroriscy_instr_prefetch.sv
// Instruction prefetch unit between the instruction memory port and IF.
// Issues word-aligned fetches (at most one outstanding), buffers the
// returned words and presents realigned instructions with their PC.
// Branches flush the buffer and redirect fetching; data of a transaction
// that was in flight at the branch is discarded.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_i           : core wants instructions
//   branch_i/addr_i : redirect request and halfword-aligned target
//   ready_i         : IF consumes the presented instruction
//   valid_o/rdata_o/addr_o : presented instruction, its parcel and PC
//   instr_req_o/instr_addr_o/instr_gnt_i : memory request handshake
//   instr_rvalid_i/instr_rdata_i         : memory read response
//   busy_o          : memory transaction outstanding
module zeroriscy_instr_prefetch
  import zeroriscy_defines::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q;
  logic [31:0]  target_q, target_d;
  logic [31:0]  branch_word, next_addr;
  logic         room, push, issue;

  assign branch_word = {addr_i[31:2], 2'b00};
  assign next_addr   = branch_i ? branch_word : fetch_addr_q + 32'd4;
  assign issue       = (req_i & room) | branch_i;
  // Only data of a live transaction is kept; a same-cycle branch drops it.
  assign push        = (state_q == WAIT_RVALID) & instr_rvalid_i & ~branch_i;

  // target_q holds the address of a request waiting for its grant, and the
  // redirect target while an aborted transaction drains.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          instr_req_o  = 1'b1;
          instr_addr_o = next_addr;
          target_d     = next_addr;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = branch_i ? branch_word : target_q;
        target_d     = instr_addr_o;
        if (instr_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          if (issue) begin
            instr_req_o  = 1'b1;
            instr_addr_o = next_addr;
            target_d     = next_addr;
            state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end else begin
            state_d = IDLE;
          end
        end else if (branch_i) begin
          target_d = branch_word;
          state_d  = WAIT_ABORTED;
        end
      end
      WAIT_ABORTED: begin
        if (instr_rvalid_i) begin
          instr_req_o  = 1'b1;
          instr_addr_o = branch_i ? branch_word : target_q;
          target_d     = instr_addr_o;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else if (branch_i) begin
          target_d = branch_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      target_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (instr_req_o && instr_gnt_i) fetch_addr_q <= instr_addr_o;
    end
  end

  assign busy_o = state_q != IDLE;

  zeroriscy_fetch_fifo #(
    .DEPTH(DEPTH)
  ) fifo_i (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (branch_i),
    .clear_addr(addr_i),
    .push      (push),
    .push_data (instr_rdata_i),
    .ready     (ready_i),
    .valid     (valid_o),
    .rdata     (rdata_o),
    .addr      (addr_o),
    .room      (room)
  );

endmodule

// File: tb/tb_zeroriscy_instr_prefetch.sv
// Bench for zeroriscy_instr_prefetch: a memory slave with configurable
// grant rate and latency, an instruction-stream model (PC walks memory
// halfword by halfword from the last branch target) and a fetch-order model
// (fetches walk word by word from the last branch target).
module tb_zeroriscy_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  zeroriscy_instr_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .addr_i        (addr_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] mem_ovr [logic [31:0]];
  int          gnt_pct = 100, lat_min = 0, lat_max = 0;
  logic        req_knob = 1'b0;
  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_wait = 0;
  bit          model_on = 1'b0;
  logic [31:0] model_pc = '0, exp_fetch = '0;
  logic [31:0] cons_addr [$];
  int          n_consumed = 0, n_gnt = 0;
  logic        obs_valid, obs_req, obs_gnt, obs_rvalid;
  logic [31:0] obs_addr, obs_rdata, obs_iaddr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hash_half(input logic [31:0] a);
    logic [31:0] x;
    x = a * 32'h9E3779B1;
    x = x ^ (x >> 13);
    x = x * 32'h85EBCA6B;
    x = x ^ (x >> 16);
    return x[15:0];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem_ovr.exists(wa)) return mem_ovr[wa];
    return {hash_half(wa + 32'd2), hash_half(wa)};
  endfunction

  function automatic logic [15:0] mem_half(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // One clock cycle: drive inputs at the falling edge, let the memory slave
  // answer, observe, and advance the models for what the rising edge commits.
  task automatic step(input logic br, input logic [31:0] ba, input logic rdy);
    logic [15:0] lo, hi;
    @(negedge clk);
    branch_i       = br;
    addr_i         = ba;
    ready_i        = rdy;
    req_i          = req_knob;
    instr_rvalid_i = mem_pending && (mem_wait == 0);
    instr_rdata_i  = instr_rvalid_i ? mem_word(mem_addr) : $urandom();
    instr_gnt_i    = 1'b0;
    #1;
    obs_req     = instr_req_o;
    obs_iaddr   = instr_addr_o;
    instr_gnt_i = instr_req_o && ($urandom_range(0, 99) < gnt_pct);
    #1;
    obs_gnt    = instr_req_o && instr_gnt_i;
    obs_valid  = valid_o;
    obs_addr   = addr_o;
    obs_rdata  = rdata_o;
    obs_rvalid = instr_rvalid_i;
    if (br) begin
      model_on  = 1'b1;
      model_pc  = ba;
      exp_fetch = {ba[31:2], 2'b00};
      cons_addr.delete();
    end else if (!model_on) begin
      check_val("idle_valid", 32'(valid_o), 32'd0);
    end else if (valid_o && rdy) begin
      lo = mem_half(model_pc);
      hi = mem_half(model_pc + 32'd2);
      check_val("pc", addr_o, model_pc);
      cons_addr.push_back(addr_o);
      n_consumed++;
      if (lo[1:0] != 2'b11) begin
        check_val("rvc_parcel", {16'h0, rdata_o[15:0]}, {16'h0, lo});
        model_pc = model_pc + 32'd2;
      end else begin
        check_val("rv32_parcel", rdata_o, {hi, lo});
        model_pc = model_pc + 32'd4;
      end
    end
    if (obs_gnt) begin
      n_gnt++;
      check_val("fetch_align", 32'(obs_iaddr[1:0]), 32'd0);
      check_val("one_outstanding", 32'(mem_pending && !instr_rvalid_i), 32'd0);
      if (model_on) begin
        check_val("fetch_addr", obs_iaddr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (instr_rvalid_i) mem_pending = 1'b0;
    else if (mem_pending && mem_wait > 0) mem_wait--;
    if (obs_gnt) begin
      mem_pending = 1'b1;
      mem_addr    = obs_iaddr;
      mem_wait    = $urandom_range(lat_min, lat_max);
    end
  endtask

  initial begin
    int g0, c0;
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0; addr_i = '0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    mem_ovr[32'h80]  = 32'h00000013;
    mem_ovr[32'h84]  = 32'h00100093;
    mem_ovr[32'h88]  = 32'h00000013;
    mem_ovr[32'h100] = 32'h00010001;
    mem_ovr[32'h104] = 32'h00000013;
    mem_ovr[32'h200] = 32'h00130000;
    mem_ovr[32'h204] = 32'h00000001;
    mem_ovr[32'h500] = 32'h00000013;
    mem_ovr[32'h504] = 32'h00000013;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_rdata", rdata_o, 32'd0);
    check_val("rst_addr", addr_o, 32'd0);
    check_val("rst_req", 32'(instr_req_o), 32'd0);
    check_val("rst_iaddr", instr_addr_o, 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait memory, aligned 32-bit stream from 0x80
    req_knob = 1'b1; gnt_pct = 100; lat_min = 0; lat_max = 0;
    step(1'b1, 32'h80, 1'b0);
    check_val("t1_req", 32'(obs_req), 32'd1);
    check_val("t1_iaddr0", obs_iaddr, 32'h80);
    step(1'b0, 32'h0, 1'b0);
    check_val("t1_lat_c1", 32'(obs_valid), 32'd0);
    check_val("t1_iaddr1", obs_iaddr, 32'h84);
    step(1'b0, 32'h0, 1'b1);
    check_val("t1_lat_c2", 32'(obs_valid), 32'd1);
    check_val("t1_addr0", obs_addr, 32'h80);
    check_val("t1_rdata0", obs_rdata, 32'h00000013);
    step(1'b0, 32'h0, 1'b1);
    check_val("t1_addr1", obs_addr, 32'h84);
    check_val("t1_rdata1", obs_rdata, 32'h00100093);

    // compressed stream
    step(1'b1, 32'h100, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);
    check_val("t2_count", 32'(cons_addr.size() >= 3), 32'd1);
    if (cons_addr.size() >= 3) begin
      check_val("t2_pc0", cons_addr[0], 32'h100);
      check_val("t2_pc1", cons_addr[1], 32'h102);
      check_val("t2_pc2", cons_addr[2], 32'h104);
    end

    // unaligned 32-bit target spanning two words
    step(1'b1, 32'h202, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_val("t3_wait_2nd", 32'(obs_valid), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check_val("t3_valid", 32'(obs_valid), 32'd1);
    check_val("t3_rdata", obs_rdata, 32'h00010013);
    check_val("t3_addr", obs_addr, 32'h202);
    step(1'b0, 32'h0, 1'b1);
    check_val("t3_next", obs_addr, 32'h206);

    // branch while a transaction awaits its data
    lat_min = 2; lat_max = 2;
    step(1'b1, 32'h300, 1'b1);
    step(1'b1, 32'h400, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    lat_min = 0; lat_max = 0;
    step(1'b0, 32'h0, 1'b1);
    check_val("t4_rvalid", 32'(obs_rvalid), 32'd1);
    check_val("t4_req", 32'(obs_req), 32'd1);
    check_val("t4_iaddr", obs_iaddr, 32'h400);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    check_val("t4_count", 32'(cons_addr.size() > 0), 32'd1);
    if (cons_addr.size() > 0) check_val("t4_first_pc", cons_addr[0], 32'h400);

    // consumer stalled: buffer fills to DEPTH-1 words, then fetching stops
    g0 = n_gnt;
    step(1'b1, 32'h500, 1'b0);
    repeat (8) step(1'b0, 32'h0, 1'b0);
    check_val("t5_grants", 32'(n_gnt - g0), 32'd2);
    check_val("t5_req_low", 32'(obs_req), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check_val("t5_refill", 32'(obs_req), 32'd1);

    // branch wins over a same-cycle consume
    step(1'b1, 32'h600, 1'b1);
    check_val("t6_pre_valid", 32'(obs_valid), 32'd1);
    step(1'b0, 32'h0, 1'b0);
    check_val("t6_addr", obs_addr, 32'h600);
    check_val("t6_valid", 32'(obs_valid), 32'd0);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // reset mid-transaction, late data must be ignored
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h700, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    req_knob = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
    rst_n = 1'b0;
    model_on = 1'b0;
    #1;
    check_val("t7_busy", 32'(busy_o), 32'd0);
    check_val("t7_valid", 32'(valid_o), 32'd0);
    check_val("t7_addr", addr_o, 32'd0);
    check_val("t7_req", 32'(instr_req_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 32'h0, 1'b0);
    check_val("t7_busy_after", 32'(busy_o), 32'd0);

    // randomized traffic
    gnt_pct = 60; lat_min = 0; lat_max = 3; req_knob = 1'b1;
    c0 = n_consumed;
    step(1'b1, 32'h0001_0000, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      req_knob = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 3)
        step(1'b1, 32'h0001_0000 + ($urandom_range(0, 2047) << 1), $urandom_range(0, 9) < 7);
      else
        step(1'b0, $urandom(), $urandom_range(0, 9) < 7);
    end
    check_val("rand_progress", 32'((n_consumed - c0) > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
